// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing an external NAND 4:1 mux.
// Define MUX_ARB_EARLY_REL_EN to release a grant as soon as its request drops.
module mux_rr_arbiter #(
  parameter int SETTLE = 2,
  parameter int HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mux_w,
  output logic       s0,
  output logic       s1,
  output logic [3:0] gnt,
  output logic       dout,
  output logic       dout_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GRANT
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] lst;
  logic [1:0] sel;
  logic [1:0] arb_last;
  logic       found;
  logic [1:0] pick;
  logic       grant_end;

  assign s0 = sel[0];
  assign s1 = sel[1];

  // At grant end the current owner becomes lowest priority.
  assign arb_last = (state == ST_GRANT) ? sel : lst;

`ifdef MUX_ARB_EARLY_REL_EN
  assign grant_end = (state == ST_GRANT) &&
                     ((cnt == 4'd1) || !req[sel]);
`else
  assign grant_end = (state == ST_GRANT) && (cnt == 4'd1);
`endif

  // Round-robin search starting just after the last-served index.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = arb_last + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Arbitration FSM with registered select, grant and data sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lst        <= 2'd3;
      sel        <= 2'd0;
      gnt        <= 4'd0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (state == ST_GRANT);
      if (state == ST_GRANT)
        dout <= mux_w;
      unique case (state)
        ST_IDLE: begin
          if (found) begin
            sel   <= pick;
            gnt   <= 4'd1 << pick;
            cnt   <= 4'(SETTLE);
            state <= ST_SETTLE;
          end else begin
            gnt <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'(HOLD);
            state <= ST_GRANT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_GRANT: begin
          if (grant_end) begin
            lst <= sel;
            if (!found) begin
              gnt   <= 4'd0;
              cnt   <= 4'd0;
              state <= ST_IDLE;
            end else if (pick == sel) begin
              cnt <= 4'(HOLD);
            end else begin
              sel   <= pick;
              gnt   <= 4'd1 << pick;
              cnt   <= 4'(SETTLE);
              state <= ST_SETTLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          gnt   <= 4'd0;
          cnt   <= 4'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter.
// Scoreboards track mux_w samples and the expected grant order.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic       mux_w = 1'b0;
  logic       s0, s1, dout, dout_valid;
  logic [3:0] gnt;

  int   tests = 0;
  int   fails = 0;
  logic wq[$];
  logic [3:0] gq[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.SETTLE(2), .HOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .mux_w(mux_w),
    .s0(s0),
    .s1(s1),
    .gnt(gnt),
    .dout(dout),
    .dout_valid(dout_valid)
  );

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: the mux_w value driven this cycle is what dout
  // must show after the edge whenever dout_valid is high.
  task automatic step();
    logic w;
    logic [3:0] g;
    wq.push_back(mux_w);
    @(posedge clk);
    #1;
    w = wq.pop_front();
    if (dout_valid) chk("dout_sb", 4'(dout), 4'(w));
    g = (gnt == 4'd0) ? 4'd0 : (4'd1 << {s1, s0});
    chk("gnt_inv", gnt, g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] got;
    int idx;
    logic ev;
    logic w4[4];
    w4 = '{1'b1, 1'b0, 1'b1, 1'b1};

    // reset state
    do_reset();
    chk("rst_gnt", gnt, 4'd0);
    chk("rst_sel", 4'({s1, s0}), 4'd0);
    chk("rst_dout", 4'(dout), 4'd0);
    chk("rst_valid", 4'(dout_valid), 4'd0);

    // no requests: stays idle
    repeat (6) step();
    chk("idle_gnt", gnt, 4'd0);
    chk("idle_sel", 4'({s1, s0}), 4'd0);
    chk("idle_valid", 4'(dout_valid), 4'd0);

    // single requester a, continuous grant
    req = 4'b0001;
    step();
    chk("a_gnt", gnt, 4'b0001);
    chk("a_sel", 4'({s1, s0}), 4'd0);
    chk("a_v1", 4'(dout_valid), 4'd0);
    step();
    chk("a_v2", 4'(dout_valid), 4'd0);
    step();
    chk("a_v3", 4'(dout_valid), 4'd0);
    repeat (12) begin
      mux_w = 1'($urandom_range(0, 1));
      step();
      chk("a_cont_valid", 4'(dout_valid), 4'd1);
      chk("a_cont_gnt", gnt, 4'b0001);
    end

    // all requesting: a,b,c,d,a with settle gaps
    req = 4'd0;
    do_reset();
    req = 4'hf;
    gq.push_back(4'b0001);
    gq.push_back(4'b0010);
    gq.push_back(4'b0100);
    gq.push_back(4'b1000);
    gq.push_back(4'b0001);
    prev = 4'd0;
    for (int e = 1; e <= 25; e++) begin
      mux_w = 1'($urandom_range(0, 1));
      step();
      idx = ((e - 1) / 6) % 4;
      ev = (e >= 4) && (((e - 1) % 6) inside {0, 3, 4, 5});
      chk("rr_gnt", gnt, 4'd1 << idx);
      chk("rr_valid", 4'(dout_valid), 4'(ev));
      if (gnt != prev && gnt != 4'd0) begin
        if (gq.size() == 0) begin
          chk("rr_order_extra", gnt, 4'd0);
        end else begin
          got = gq.pop_front();
          chk("rr_order", gnt, got);
        end
      end
      prev = gnt;
    end
    chk("rr_order_left", 4'(gq.size()), 4'd0);

    // only d: dout follows mux_w with one-cycle lag
    req = 4'd0;
    mux_w = 1'b0;
    do_reset();
    req = 4'b1000;
    step();
    chk("d_gnt", gnt, 4'b1000);
    chk("d_sel", 4'({s1, s0}), 4'd3);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      mux_w = w4[i];
      if (i == 3) req = 4'd0;
      step();
      chk("d_dout", 4'(dout), 4'(w4[i]));
      chk("d_valid", 4'(dout_valid), 4'd1);
    end
    chk("d_idle_gnt", gnt, 4'd0);
    mux_w = 1'b0;
    repeat (3) begin
      step();
      chk("d_after_valid", 4'(dout_valid), 4'd0);
    end

    // reset in second grant cycle of c
    do_reset();
    req = 4'b0100;
    mux_w = 1'b1;
    step();
    chk("c_gnt", gnt, 4'b0100);
    chk("c_sel", 4'({s1, s0}), 4'd2);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("c_rst_gnt", gnt, 4'd0);
    chk("c_rst_sel", 4'({s1, s0}), 4'd0);
    chk("c_rst_valid", 4'(dout_valid), 4'd0);
    chk("c_rst_dout", 4'(dout), 4'd0);
    rst = 1'b0;
    step();
    chk("c_again_gnt", gnt, 4'b0100);
    chk("c_again_sel", 4'({s1, s0}), 4'd2);

    // b drops its request after one grant cycle, c waiting
    req = 4'd0;
    mux_w = 1'b0;
    do_reset();
    req = 4'b0110;
    step();
    chk("b_gnt", gnt, 4'b0010);
    step();
    step();
    step();
    req = 4'b0100;
    step();
`ifdef MUX_ARB_EARLY_REL_EN
    chk("b_early_gnt", gnt, 4'b0100);
    chk("b_early_sel", 4'({s1, s0}), 4'd2);
    chk("b_early_valid", 4'(dout_valid), 4'd1);
    step();
    chk("b_early_gap", 4'(dout_valid), 4'd0);
`else
    chk("b_hold_gnt5", gnt, 4'b0010);
    step();
    chk("b_hold_gnt6", gnt, 4'b0010);
    chk("b_hold_valid", 4'(dout_valid), 4'd1);
    step();
    chk("b_then_c_gnt", gnt, 4'b0100);
    chk("b_then_c_sel", 4'({s1, s0}), 4'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
